// File: rtl/dds_ctrl_pkg.sv
// Shared widths, limits, waveform codes and repeat-FSM types for the DDS control path.
// Package name is dds_pkg; the file is named after the control block that owns it.
package dds_pkg;

    localparam int unsigned FREQ_IDX_W = 4;
    localparam int unsigned AMP_W      = 3;
    localparam int unsigned WAVE_W     = 2;
    localparam int unsigned TW_W       = 32;

    localparam logic [FREQ_IDX_W-1:0] FREQ_IDX_MAX = 4'd15;
    localparam logic [AMP_W-1:0]      AMP_MAX      = 3'd7;

    localparam logic [WAVE_W-1:0] WAVE_SINE   = 2'd0;
    localparam logic [WAVE_W-1:0] WAVE_SQUARE = 2'd1;
    localparam logic [WAVE_W-1:0] WAVE_TRI    = 2'd2;
    localparam logic [WAVE_W-1:0] WAVE_SAW    = 2'd3;

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned BTN_U   = 0;
    localparam int unsigned BTN_D   = 1;
    localparam int unsigned BTN_R   = 2;
    localparam int unsigned BTN_L   = 3;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    // One-hot of the lowest set bit; picks a single button when several press together.
    function automatic logic [NUM_BTN-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/dds_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced level and press pulse.
// The debounced level is exported only when DDS_CTRL_AUTOREPEAT_EN is defined.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
`ifdef DDS_CTRL_AUTOREPEAT_EN
    output logic stable,
`endif
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             level;

    // Terminal count places the level change DEBOUNCE_CYCLES+2 edges after raw is first sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                level <= ~level;
                cnt   <= '0;
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DDS_CTRL_AUTOREPEAT_EN
    assign stable = level;
`endif

endmodule

// File: rtl/dds_ctrl.sv
// DDS user-control sequencer: debounced buttons step frequency index and amplitude, switches pick
// the waveform; outputs are registered with a one-cycle cfg_update. Option: DDS_CTRL_AUTOREPEAT_EN.
module dds_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 5000,
    parameter logic [31:0] TW_STEP         = 32'd42950,
    parameter int unsigned FREQ_IDX_RST    = 0,
    parameter int unsigned AMP_RST         = 4,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            sw,
    input  logic                  btnU_raw,
    input  logic                  btnD_raw,
    input  logic                  btnR_raw,
    input  logic                  btnL_raw,
    output logic [FREQ_IDX_W-1:0] freq_idx,
    output logic [TW_W-1:0]       tuning_word,
    output logic [AMP_W-1:0]      amplitude,
    output logic [WAVE_W-1:0]     wave_sel,
    output logic                  cfg_update
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("dds_ctrl: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
    end

    function automatic logic [TW_W-1:0] tw_for(input logic [FREQ_IDX_W-1:0] idx);
        return TW_STEP * (TW_W'(idx) + 1'b1);
    endfunction

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] step;
    logic               unused_sw;

    assign raw_vec   = {btnL_raw, btnR_raw, btnD_raw, btnU_raw};
    assign unused_sw = ^sw[3:2];

`ifdef DDS_CTRL_AUTOREPEAT_EN
    logic [NUM_BTN-1:0] btn_stable;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock (clock),
            .reset (reset),
            .raw   (raw_vec[i]),
`ifdef DDS_CTRL_AUTOREPEAT_EN
            .stable(btn_stable[i]),
`endif
            .press (press_vec[i])
        );
    end

`ifdef DDS_CTRL_AUTOREPEAT_EN
    rpt_state_t         rpt_state;
    logic [NUM_BTN-1:0] rpt_btn;
    logic [NUM_BTN-1:0] rpt_step;
    logic [31:0]        rpt_cnt;
    logic               rpt_release;

    // Leave repeat when the latched button drops or any other button is held.
    assign rpt_release = ((btn_stable & rpt_btn) == '0) || ((btn_stable & ~rpt_btn) != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_state <= RPT_IDLE;
            rpt_btn   <= '0;
            rpt_cnt   <= '0;
            rpt_step  <= '0;
        end else begin
            rpt_step <= '0;
            case (rpt_state)
                RPT_IDLE: begin
                    if (press_vec != '0) begin
                        rpt_state <= RPT_HOLD;
                        rpt_btn   <= lowest_set(press_vec);
                        rpt_cnt   <= '0;
                    end
                end
                RPT_HOLD: begin
                    if (rpt_release) begin
                        rpt_state <= RPT_IDLE;
                    end else if (rpt_cnt == 32'(REPEAT_DELAY - 1)) begin
                        rpt_state <= RPT_REPEAT;
                        rpt_cnt   <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rpt_release) begin
                        rpt_state <= RPT_IDLE;
                    end else if (rpt_cnt == 32'(REPEAT_PERIOD - 1)) begin
                        rpt_step <= rpt_btn;
                        rpt_cnt  <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: rpt_state <= RPT_IDLE;
            endcase
        end
    end

    assign step = press_vec | rpt_step;
`else
    assign step = press_vec;
`endif

    logic [FREQ_IDX_W-1:0] freq_next;
    logic [AMP_W-1:0]      amp_next;

    always_comb begin
        freq_next = freq_idx;
        if (step[BTN_U] && !step[BTN_D] && freq_idx != FREQ_IDX_MAX)
            freq_next = freq_idx + 1'b1;
        else if (step[BTN_D] && !step[BTN_U] && freq_idx != '0)
            freq_next = freq_idx - 1'b1;

        amp_next = amplitude;
        if (step[BTN_R] && !step[BTN_L] && amplitude != AMP_MAX)
            amp_next = amplitude + 1'b1;
        else if (step[BTN_L] && !step[BTN_R] && amplitude != '0)
            amp_next = amplitude - 1'b1;
    end

    // wave_q adds one stage so switch changes land three edges after sampling.
    logic [WAVE_W-1:0] sw_s1;
    logic [WAVE_W-1:0] sw_s2;
    logic [WAVE_W-1:0] wave_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1       <= '0;
            sw_s2       <= '0;
            wave_q      <= '0;
            freq_idx    <= FREQ_IDX_W'(FREQ_IDX_RST);
            tuning_word <= tw_for(FREQ_IDX_W'(FREQ_IDX_RST));
            amplitude   <= AMP_W'(AMP_RST);
            wave_sel    <= '0;
            cfg_update  <= 1'b0;
        end else begin
            sw_s1       <= sw[1:0];
            sw_s2       <= sw_s1;
            wave_q      <= sw_s2;
            freq_idx    <= freq_next;
            tuning_word <= tw_for(freq_next);
            amplitude   <= amp_next;
            wave_sel    <= wave_q;
            cfg_update  <= (freq_next != freq_idx) || (amp_next != amplitude) || (wave_q != wave_sel);
        end
    end

endmodule

// File: tb/tb_dds_ctrl.sv
// Self-checking bench for dds_ctrl: directed latency/saturation/reset steps plus random button
// and switch operations checked against a saturating-counter model.
module tb_dds_ctrl;

    localparam int unsigned DB   = 16;
    localparam int unsigned RD   = 100;
    localparam int unsigned RP   = 20;
    localparam logic [31:0] TWS  = 32'd42950;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sw = '0;
    logic        btnU_raw = 1'b0;
    logic        btnD_raw = 1'b0;
    logic        btnR_raw = 1'b0;
    logic        btnL_raw = 1'b0;
    logic [3:0]  freq_idx;
    logic [31:0] tuning_word;
    logic [2:0]  amplitude;
    logic [1:0]  wave_sel;
    logic        cfg_update;

    int n_checks  = 0;
    int n_errors  = 0;
    int pulse_cnt = 0;
    int fm = 0;
    int am = 4;
    int wm = 0;

    dds_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw         (sw),
        .btnU_raw   (btnU_raw),
        .btnD_raw   (btnD_raw),
        .btnR_raw   (btnR_raw),
        .btnL_raw   (btnL_raw),
        .freq_idx   (freq_idx),
        .tuning_word(tuning_word),
        .amplitude  (amplitude),
        .wave_sel   (wave_sel),
        .cfg_update (cfg_update)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (cfg_update === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] m);
        btnU_raw = m[0];
        btnD_raw = m[1];
        btnR_raw = m[2];
        btnL_raw = m[3];
    endtask

    // Saturating step rules on the model; returns 1 when any output would change.
    function automatic bit model_step(input logic [3:0] m);
        int f0 = fm;
        int a0 = am;
        if (m[0] && !m[1] && fm < 15) fm++;
        else if (m[1] && !m[0] && fm > 0) fm--;
        if (m[2] && !m[3] && am < 7) am++;
        else if (m[3] && !m[2] && am > 0) am--;
        return (fm != f0) || (am != a0);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_freq"}, 32'(freq_idx), 32'(fm));
        check({tag, "_tw"}, tuning_word, 32'(TWS * 32'(fm + 1)));
        check({tag, "_amp"}, 32'(amplitude), 32'(am));
        check({tag, "_wave"}, 32'(wave_sel), 32'(wm));
    endtask

    task automatic press_op(input logic [3:0] m, input int unsigned hold, input string tag);
        int exp_p;
        exp_p = model_step(m) ? 1 : 0;
        pulse_cnt = 0;
        set_btns(m);
        tick(hold);
        set_btns('0);
        tick(DB + 12);
        check({tag, "_pulses"}, 32'(pulse_cnt), 32'(exp_p));
        check_outputs(tag);
    endtask

    initial begin
        int n_rep;
        logic [3:0] m;
        logic [3:0] s;
        int exp_p;

        // Reset and idle
        tick(3);
        reset = 1'b0;
        pulse_cnt = 0;
        tick(50);
        check_outputs("reset");
        check("reset_tw_const", tuning_word, 32'd42950);
        check("idle_pulses", 32'(pulse_cnt), 32'd0);

        // Exact press latency: edge 0 is the first edge sampling raw high
        pulse_cnt = 0;
        set_btns(4'b0001);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i == 18) begin
                check("lat_before_freq", 32'(freq_idx), 32'd0);
                check("lat_before_upd", 32'(cfg_update), 32'd0);
            end
            if (i == 19) begin
                check("lat_freq", 32'(freq_idx), 32'd1);
                check("lat_tw", tuning_word, 32'd85900);
                check("lat_upd", 32'(cfg_update), 32'd1);
            end
            if (i == 20) check("lat_after_upd", 32'(cfg_update), 32'd0);
        end
        set_btns('0);
        tick(DB + 12);
        void'(model_step(4'b0001));
        check("lat_pulses", 32'(pulse_cnt), 32'd1);

        // Glitch shorter than the debounce window
        pulse_cnt = 0;
        set_btns(4'b0001);
        tick(10);
        set_btns('0);
        tick(DB + 12);
        check("glitch_pulses", 32'(pulse_cnt), 32'd0);
        check_outputs("glitch");

        // Frequency saturation
        for (int i = 0; i < 20; i++) press_op(4'b0001, DB + 8, "sat_up");
        check("sat_freq", 32'(freq_idx), 32'd15);
        check("sat_tw", tuning_word, 32'd687200);

        // U+D cancel while R applies
        press_op(4'b0111, DB + 8, "udr");
        check("udr_amp", 32'(amplitude), 32'd5);

        for (int i = 0; i < 6; i++) press_op(4'b0100, DB + 8, "amp_up");
        check("amp_sat", 32'(amplitude), 32'd7);

        // Waveform switch latency
        pulse_cnt = 0;
        sw = 4'd2;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (i == 2) check("sw_before", 32'(wave_sel), 32'd0);
            if (i == 3) begin
                check("sw_wave", 32'(wave_sel), 32'd2);
                check("sw_upd", 32'(cfg_update), 32'd1);
            end
            if (i == 4) check("sw_after_upd", 32'(cfg_update), 32'd0);
        end
        wm = 2;
        check("sw_pulses", 32'(pulse_cnt), 32'd1);

        // Reset in the middle of an L debounce, L held across release
        set_btns(4'b1000);
        tick(8);
        reset = 1'b1;
        sw = 4'd0;
        tick(2);
        fm = 0; am = 4; wm = 0;
        check_outputs("rst_mid");
        check("rst_mid_upd", 32'(cfg_update), 32'd0);
        reset = 1'b0;
        for (int i = 0; i <= int'(DB) + 4; i++) begin
            tick(1);
            if (i == int'(DB) + 2) check("rst_hold_amp", 32'(amplitude), 32'd4);
            if (i == int'(DB) + 3) check("rst_press_amp", 32'(amplitude), 32'd3);
        end
        set_btns('0);
        tick(DB + 12);
        void'(model_step(4'b1000));
        check_outputs("rst_after");

        // Long hold of D from index 10
        for (int i = 0; i < 10; i++) press_op(4'b0001, DB + 8, "to10");
        check("to10_freq", 32'(freq_idx), 32'd10);
        n_rep = 0;
`ifdef DDS_CTRL_AUTOREPEAT_EN
        for (int k = 1; RD + k * RP < 200; k++) n_rep++;
`endif
        pulse_cnt = 0;
        set_btns(4'b0010);
        tick(200);
        set_btns('0);
        tick(DB + 12 + RP);
        for (int k = 0; k <= n_rep; k++) void'(model_step(4'b0010));
        check_outputs("hold_d");
        check("hold_d_pulses", 32'(pulse_cnt), 32'(n_rep + 1));

        // Random operations against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                s = 4'($urandom_range(0, 15));
                exp_p = (int'(s[1:0]) != wm) ? 1 : 0;
                pulse_cnt = 0;
                sw = s;
                tick(6);
                wm = int'(s[1:0]);
                check("rnd_sw_pulses", 32'(pulse_cnt), 32'(exp_p));
                check("rnd_sw_wave", 32'(wave_sel), 32'(wm));
            end else begin
                m = 4'($urandom_range(1, 15));
                press_op(m, $urandom_range(DB + 4, 40), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
